// File: rtl/msrv32_dmem_pkg.sv
`default_nettype none
// ==== msrv32_dmem_pkg : shared constants for the data-memory responder ====
// ==== Rev 1.0                                                           ====
package msrv32_dmem_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  // Fault reasons; the trap unit uses the same codes.
  typedef logic [1:0] fault_t;
  localparam fault_t FAULT_NONE       = 2'd0;
  localparam fault_t FAULT_MISALIGNED = 2'd1;
  localparam fault_t FAULT_RANGE      = 2'd2;

  function automatic fault_t classify_fault(input logic misaligned, input logic out_of_range);
    if (misaligned) return FAULT_MISALIGNED;
    if (out_of_range) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_dmem_responder_if.sv
`default_nettype none
// ==== msrv32_dmem_responder_if : request/response channels of the dmem responder ====
// ==== Rev 1.0                                                                    ====
interface msrv32_dmem_responder_if #(
  parameter int ADDR_W = 32
);
  import msrv32_dmem_pkg::*;

  logic                req_valid_in;
  logic                req_ready_out;
  logic                req_wr_in;
  logic [ADDR_W-1:0]   req_addr_in;
  logic [WORD_W-1:0]   req_wdata_in;
  logic [MASK_W-1:0]   req_wmask_in;
  logic                rsp_valid_out;
  logic                rsp_ready_in;
  logic [WORD_W-1:0]   rsp_rdata_out;
  logic                rsp_err_out;

  modport master (
    output req_valid_in, req_wr_in, req_addr_in, req_wdata_in, req_wmask_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
  );

  modport slave (
    input  req_valid_in, req_wr_in, req_addr_in, req_wdata_in, req_wmask_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
  );

endinterface
`default_nettype wire

// File: rtl/msrv32_dmem_ram.sv
`default_nettype none
// ==== msrv32_dmem_ram : DEPTH x 32 single-port RAM, byte-enable write, async read ====
// ==== Rev 1.0                                                                     ====
module msrv32_dmem_ram
  import msrv32_dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MASK_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // One bank per byte lane so each lane has a single writer.
  for (genvar lane = 0; lane < MASK_W; lane++) begin : g_lane
    logic [BYTE_W-1:0] bank [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[lane]) begin
        bank[idx] <= wdata[BYTE_W*lane +: BYTE_W];
      end
    end

    assign rdata[BYTE_W*lane +: BYTE_W] = bank[idx];
  end

endmodule
`default_nettype wire

// File: rtl/msrv32_dmem_responder.sv
`default_nettype none
// ==== msrv32_dmem_responder : valid/ready data-memory responder with wait states ====
// ==== Rev 1.0                                                                     ====
module msrv32_dmem_responder
  import msrv32_dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  msrv32_dmem_responder_if.slave  bus
);

  localparam int                 IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    LIMIT    = (ADDR_W+1)'(DEPTH) << 2;
  localparam logic [CNT_W-1:0]   CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic clk;
  logic rst;
  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [WORD_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_accept;
  logic                w_access;
  logic                w_live;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [WORD_W-1:0]   w_acc_wdata;
  logic [MASK_W-1:0]   w_acc_wmask;
  fault_t              w_fault;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;
  logic                w_ram_we;
  logic [WORD_W-1:0]   w_ram_rdata;

  assign w_accept = (state == IDLE) && bus.req_valid_in;
  assign w_access = (w_accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (r_cnt == '0));

  // A zero-wait access happens on the accept edge, so it must use the live request.
  assign w_live      = (state == IDLE);
  assign w_acc_wr    = w_live ? bus.req_wr_in    : r_wr;
  assign w_acc_addr  = w_live ? bus.req_addr_in  : r_addr;
  assign w_acc_wdata = w_live ? bus.req_wdata_in : r_wdata;
  assign w_acc_wmask = w_live ? bus.req_wmask_in : r_wmask;

  assign w_fault  = classify_fault(w_acc_addr[1:0] != 2'b00, {1'b0, w_acc_addr} >= LIMIT);
  assign w_err    = (w_fault != FAULT_NONE);
  assign w_idx    = w_acc_addr[IDX_W+1:2];
  assign w_ram_we = w_access && w_acc_wr && !w_err && !rst;

  msrv32_dmem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .be    (w_acc_wmask),
    .idx   (w_idx),
    .wdata (w_acc_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (w_accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_out = (state == IDLE);
    bus.rsp_valid_out = (state == RESP);
    bus.rsp_rdata_out = r_rdata;
    bus.rsp_err_out   = r_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_accept) begin
            r_wr    <= bus.req_wr_in;
            r_addr  <= bus.req_addr_in;
            r_wdata <= bus.req_wdata_in;
            r_wmask <= bus.req_wmask_in;
            r_cnt   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        RESP: begin
        end
        default: begin
          r_cnt   <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
      endcase
      if (w_access) begin
        r_rdata <= (w_err || w_acc_wr) ? '0 : w_ram_rdata;
        r_err   <= w_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_dmem_responder.sv
`default_nettype none
// ==== tb_msrv32_dmem_responder : scoreboard bench for three responder configurations ====
// ==== Rev 1.0                                                                        ====
module tb_msrv32_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3, rst2;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];
  logic [31:0] model [1024];

  // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=3, index 2: WAIT_CYCLES=2.
  logic        t_req_valid [3];
  logic        t_req_wr    [3];
  logic [31:0] t_addr      [3];
  logic [31:0] t_wdata     [3];
  logic [3:0]  t_mask      [3];
  logic        t_rsp_ready [3];
  logic        o_req_ready [3];
  logic        o_rsp_valid [3];
  logic [31:0] o_rdata     [3];
  logic        o_err       [3];

  msrv32_dmem_responder_if #(.ADDR_W(32)) bus0 ();
  msrv32_dmem_responder_if #(.ADDR_W(32)) bus3 ();
  msrv32_dmem_responder_if #(.ADDR_W(32)) bus2 ();

  msrv32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .ms_riscv32_mp_clk_in (clk), .ms_riscv32_mp_rst_in (rst0), .bus (bus0.slave));
  msrv32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3), .ADDR_W(32)) dut3 (
    .ms_riscv32_mp_clk_in (clk), .ms_riscv32_mp_rst_in (rst3), .bus (bus3.slave));
  msrv32_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .ADDR_W(32)) dut2 (
    .ms_riscv32_mp_clk_in (clk), .ms_riscv32_mp_rst_in (rst2), .bus (bus2.slave));

  assign bus0.req_valid_in = t_req_valid[0];  assign bus3.req_valid_in = t_req_valid[1];  assign bus2.req_valid_in = t_req_valid[2];
  assign bus0.req_wr_in    = t_req_wr[0];     assign bus3.req_wr_in    = t_req_wr[1];     assign bus2.req_wr_in    = t_req_wr[2];
  assign bus0.req_addr_in  = t_addr[0];       assign bus3.req_addr_in  = t_addr[1];       assign bus2.req_addr_in  = t_addr[2];
  assign bus0.req_wdata_in = t_wdata[0];      assign bus3.req_wdata_in = t_wdata[1];      assign bus2.req_wdata_in = t_wdata[2];
  assign bus0.req_wmask_in = t_mask[0];       assign bus3.req_wmask_in = t_mask[1];       assign bus2.req_wmask_in = t_mask[2];
  assign bus0.rsp_ready_in = t_rsp_ready[0];  assign bus3.rsp_ready_in = t_rsp_ready[1];  assign bus2.rsp_ready_in = t_rsp_ready[2];
  assign o_req_ready[0] = bus0.req_ready_out; assign o_req_ready[1] = bus3.req_ready_out; assign o_req_ready[2] = bus2.req_ready_out;
  assign o_rsp_valid[0] = bus0.rsp_valid_out; assign o_rsp_valid[1] = bus3.rsp_valid_out; assign o_rsp_valid[2] = bus2.rsp_valid_out;
  assign o_rdata[0]     = bus0.rsp_rdata_out; assign o_rdata[1]     = bus3.rsp_rdata_out; assign o_rdata[2]     = bus2.rsp_rdata_out;
  assign o_err[0]       = bus0.rsp_err_out;   assign o_err[1]       = bus3.rsp_err_out;   assign o_err[2]       = bus2.rsp_err_out;

  // Reference memory for the zero-wait instance.
  function automatic exp_t model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] mask);
    exp_t e;
    logic [9:0] idx;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    idx     = addr[11:2];
    if (addr[1:0] != 2'b00 || addr >= 32'h0000_1000) begin
      e.err = 1'b1;
      return e;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) if (mask[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      e.rdata = model[idx];
    end
    return e;
  endfunction

  function automatic exp_t sb_pop();
    exp_t e;
    e.rdata = 32'hBAD0_BAD0;
    e.err   = 1'b1;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // One transaction with rsp_ready held high; lat = cycles from accept to rsp_valid, -1 on timeout.
  task automatic send(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata, output logic err, output int lat);
    int n;
    rdata = 32'h0;
    err   = 1'b0;
    lat   = -1;
    @(negedge clk);
    t_req_valid[d] = 1'b1; t_req_wr[d] = wr; t_addr[d] = addr; t_wdata[d] = wdata; t_mask[d] = mask;
    t_rsp_ready[d] = 1'b1;
    n = 0;
    while (o_req_ready[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (o_req_ready[d] !== 1'b1) begin t_req_valid[d] = 1'b0; return; end
    @(negedge clk);
    t_req_valid[d] = 1'b0; t_req_wr[d] = ~wr; t_addr[d] = ~addr; t_wdata[d] = ~wdata; t_mask[d] = ~mask;
    n = 1;
    while (o_rsp_valid[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (o_rsp_valid[d] !== 1'b1) return;
    lat   = n;
    rdata = o_rdata[d];
    err   = o_err[d];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
    for (int d = 0; d < 3; d++) begin
      t_req_valid[d] = 1'b0; t_req_wr[d] = 1'b0; t_addr[d] = 32'h0;
      t_wdata[d] = 32'h0; t_mask[d] = 4'h0; t_rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_req_ready[d] !== 1'b1 || o_rsp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_handshake[%0d]: ready=%b valid=%b want ready=1 valid=0", d, o_req_ready[d], o_rsp_valid[d]);
      end
      checks++;
      if (o_rdata[d] !== 32'h0 || o_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_rsp[%0d]: rdata=%h err=%b want 0/0", d, o_rdata[d], o_err[d]);
      end
    end
  endtask

  task automatic run_table0(input string name, input op_t ops [], input int n_ops);
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < n_ops; i++) begin
      sb.push_back(model_apply(ops[i].wr, ops[i].addr, ops[i].wdata, ops[i].mask));
      send(0, ops[i].wr, ops[i].addr, ops[i].wdata, ops[i].mask, rd, er, lat);
      e = sb_pop();
      checks++;
      if (lat != 1) begin
        failures++;
        $display("FAIL %s[%0d] latency: got %0d want 1", name, i, lat);
      end
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        failures++;
        $display("FAIL %s[%0d] addr=%h: rdata=%h err=%b want rdata=%h err=%b", name, i, ops[i].addr, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_write_read();
    op_t ops [];
    ops = new[2];
    ops[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF};
    ops[1] = '{1'b0, 32'h10, 32'h0, 4'h0};
    run_table0("write_read", ops, 2);
  endtask

  task automatic test_byte_mask();
    op_t ops [];
    ops = new[5];
    ops[0] = '{1'b1, 32'h20, 32'h1122_3344, 4'hF};
    ops[1] = '{1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101};
    ops[2] = '{1'b0, 32'h20, 32'h0, 4'h0};
    ops[3] = '{1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000};
    ops[4] = '{1'b0, 32'h20, 32'h0, 4'h0};
    run_table0("byte_mask", ops, 5);
    checks++;
    if (model[8] !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL byte_mask_model: got %h want 11bb33dd", model[8]);
    end
  endtask

  task automatic test_faults();
    op_t ops [];
    ops = new[10];
    ops[0] = '{1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'hF};
    ops[1] = '{1'b0, 32'h0000_0022, 32'h0, 4'h0};
    ops[2] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF};
    ops[3] = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF};
    ops[4] = '{1'b1, 32'h0000_0FFC, 32'h600D_F00D, 4'hF};
    ops[5] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0};
    ops[6] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0};
    ops[7] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0};
    ops[8] = '{1'b0, 32'h0000_0FFC, 32'h0, 4'h0};
    ops[9] = '{1'b0, 32'h0000_1000, 32'h0, 4'h0};
    run_table0("faults", ops, 10);
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rsp = 0;
    exp_t e;
    @(negedge clk);
    t_req_valid[0] = 1'b1; t_req_wr[0] = 1'b0; t_addr[0] = 32'h10; t_rsp_ready[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (o_req_ready[0]) begin acc++; sb.push_back(model_apply(1'b0, 32'h10, 32'h0, 4'h0)); end
      if (o_rsp_valid[0]) begin
        rsp++;
        e = sb_pop();
        checks++;
        if (o_rdata[0] !== e.rdata || o_err[0] !== e.err) begin
          failures++;
          $display("FAIL b2b_data k=%0d: rdata=%h err=%b want %h/%b", k, o_rdata[0], o_err[0], e.rdata, e.err);
        end
      end
      if (k == 9) t_req_valid[0] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (acc != 5 || rsp != 5) begin
      failures++;
      $display("FAIL b2b_throughput: accepts=%0d responses=%0d want 5/5", acc, rsp);
    end
  endtask

  task automatic test_wait_backpressure();
    logic [31:0] rd; logic er; int lat; exp_t e;
    sb.push_back('{32'h0, 1'b0});
    send(1, 1'b1, 32'h80, 32'hA5A5_5A5A, 4'hF, rd, er, lat);
    e = sb_pop();
    checks++;
    if (lat != 4 || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL wait_write: lat=%0d err=%b rdata=%h want 4/%b/%h", lat, er, rd, e.err, e.rdata);
    end
    @(negedge clk);
    t_req_valid[1] = 1'b1; t_req_wr[1] = 1'b0; t_addr[1] = 32'h80; t_rsp_ready[1] = 1'b0;
    checks++;
    if (o_req_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL wait_idle_ready: got %b want 1", o_req_ready[1]);
    end
    sb.push_back('{32'hA5A5_5A5A, 1'b0});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      t_req_valid[1] = (k < 10); t_req_wr[1] = 1'b1; t_wdata[1] = 32'h0; t_mask[1] = 4'hF;
      if (k == 10) t_rsp_ready[1] = 1'b1;
      checks++;
      if (o_rsp_valid[1] !== 1'(k >= 4 && k <= 10) || o_req_ready[1] !== 1'(k == 11)) begin
        failures++;
        $display("FAIL wait_handshake cycle+%0d: valid=%b ready=%b want %b/%b", k, o_rsp_valid[1], o_req_ready[1],
                 1'(k >= 4 && k <= 10), 1'(k == 11));
      end
      if (k >= 4 && k <= 10 && sb.size() > 0) begin
        checks++;
        if (o_rdata[1] !== sb[0].rdata || o_err[1] !== sb[0].err) begin
          failures++;
          $display("FAIL wait_stable cycle+%0d: rdata=%h err=%b want %h/%b", k, o_rdata[1], o_err[1], sb[0].rdata, sb[0].err);
        end
      end
      if (k == 10) e = sb_pop();
    end
    sb.push_back('{32'hA5A5_5A5A, 1'b0});
    send(1, 1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
    e = sb_pop();
    checks++;
    if (rd !== e.rdata || er !== e.err || lat != 4) begin
      failures++;
      $display("FAIL wait_reread: rdata=%h err=%b lat=%0d want %h/%b/4", rd, er, lat, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat; exp_t e;
    sb.push_back('{32'h0, 1'b0});
    send(2, 1'b1, 32'h40, 32'h1111_1111, 4'hF, rd, er, lat);
    e = sb_pop();
    checks++;
    if (lat != 3 || er !== e.err) begin
      failures++;
      $display("FAIL midop_setup: lat=%0d err=%b want 3/%b", lat, er, e.err);
    end
    @(negedge clk);
    t_req_valid[2] = 1'b1; t_req_wr[2] = 1'b1; t_addr[2] = 32'h40; t_wdata[2] = 32'h55; t_mask[2] = 4'hF;
    t_rsp_ready[2] = 1'b1;
    checks++;
    if (o_req_ready[2] !== 1'b1) begin
      failures++;
      $display("FAIL midop_accept: ready=%b want 1", o_req_ready[2]);
    end
    @(negedge clk);
    t_req_valid[2] = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_rsp_valid[2] !== 1'b0 || o_req_ready[2] !== 1'b1) begin
        failures++;
        $display("FAIL midop_after_reset+%0d: valid=%b ready=%b want 0/1", k, o_rsp_valid[2], o_req_ready[2]);
      end
      @(negedge clk);
    end
    sb.push_back('{32'h1111_1111, 1'b0});
    send(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    e = sb_pop();
    checks++;
    if (rd !== e.rdata || er !== e.err || lat != 3) begin
      failures++;
      $display("FAIL midop_old_data: rdata=%h err=%b lat=%0d want %h/%b/3", rd, er, lat, e.rdata, e.err);
    end
  endtask

  task automatic test_stream();
    logic [31:0] rd; logic er; int lat; exp_t e;
    int issued = 0;
    int rsp_cnt = 0;
    for (int w = 0; w < 16; w++) begin
      sb.push_back(model_apply(1'b1, 32'h400 + 32'(4*w), 32'hC0DE_0000 + 32'(w), 4'hF));
      send(0, 1'b1, 32'h400 + 32'(4*w), 32'hC0DE_0000 + 32'(w), 4'hF, rd, er, lat);
      e = sb_pop();
    end
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; int n;
          wr    = 1'($urandom_range(0, 1));
          addr  = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'(4*$urandom_range(0, 15))
                                              : 32'h400 + 32'(4*$urandom_range(0, 15));
          wdata = $urandom;
          mask  = 4'($urandom_range(0, 15));
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) begin t_req_valid[0] = 1'b0; @(negedge clk); end
          t_req_valid[0] = 1'b1; t_req_wr[0] = wr; t_addr[0] = addr; t_wdata[0] = wdata; t_mask[0] = mask;
          n = 0;
          while (o_req_ready[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
          if (o_req_ready[0] !== 1'b1) begin
            checks++; failures++;
            $display("FAIL stream_accept_timeout: request %0d not accepted", i);
            t_req_valid[0] = 1'b0;
            break;
          end
          sb.push_back(model_apply(wr, addr, wdata, mask));
          issued++;
          @(posedge clk);
        end
        @(negedge clk);
        t_req_valid[0] = 1'b0;
      end
      begin
        int n = 0;
        while (rsp_cnt < 100 && n < 4000) begin
          @(negedge clk);
          n++;
          t_rsp_ready[0] = ($urandom_range(0, 2) != 0);
          if (o_rsp_valid[0] && t_rsp_ready[0]) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL stream_unexpected: response %0d with empty scoreboard rdata=%h", rsp_cnt, o_rdata[0]);
            end else begin
              e = sb.pop_front();
              if (o_rdata[0] !== e.rdata || o_err[0] !== e.err) begin
                failures++;
                $display("FAIL stream_data #%0d: rdata=%h err=%b want %h/%b", rsp_cnt, o_rdata[0], o_err[0], e.rdata, e.err);
              end
            end
            rsp_cnt++;
          end
        end
      end
    join
    t_rsp_ready[0] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_cnt != 100 || issued != 100 || sb.size() != 0 || o_rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL stream_count: responses=%0d issued=%0d pending=%0d valid=%b want 100/100/0/0",
               rsp_cnt, issued, sb.size(), o_rsp_valid[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_faults();
    test_back_to_back();
    test_wait_backpressure();
    test_reset_midop();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
